// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image byte-by-byte from a UART
// receiver and writes it word-by-word into instruction memory while holding
// the CPU. Frame: SYNC, word count N (16-bit LE), 4*N data bytes (words LE),
// one XOR checksum byte over the data bytes.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   rx_data    - received byte
//   rx_valid   - one-cycle strobe qualifying rx_data
//   imem_we    - one-cycle write pulse per assembled word
//   imem_addr  - word address (holds last value between writes)
//   imem_wdata - assembled word (holds last value between writes)
//   cpu_hold   - 1 freezes the CPU; released only once the image is good
//   done       - image loaded and checksum good
//   error      - last frame aborted (bad length, checksum or timeout)
module uart_boot_loader #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = 8'hB0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCheck,
        StDone,
        StErr
    } state_e;

    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;
    localparam logic [31:0] TmoLast  = 32'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [15:0]       n_rx;
    logic              tmo_active;

    assign n_rx       = {rx_data, len_q[7:0]};
    assign tmo_active = (state_q == StLenLo) || (state_q == StLenHi) ||
                        (state_q == StData)  || (state_q == StCheck);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = StLenLo;
                    tmo_d   = '0;
                end
            end
            StLenLo: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (rx_valid) begin
                    len_d = n_rx;
                    if (n_rx == 16'd0 || {1'b0, n_rx} > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d    = StData;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        csum_d     = '0;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Write is registered so the pulse lands the cycle after the 4th byte.
                        we_d       = 1'b1;
                        addr_d     = word_idx_q[ADDR_W-1:0];
                        wdata_d    = {rx_data, asm_q[23:0]};
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_d == len_q) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? StDone : StErr;
                end
            end
            StDone: begin
                // Terminal until reset.
            end
            StErr: begin
                if (rx_valid && rx_data == SYNC) begin
                    state_d = StLenLo;
                    tmo_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A byte in the expiry cycle wins over the timeout.
        if (tmo_active) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TmoLast) begin
                tmo_d   = '0;
                state_d = StErr;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != StDone);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StErr);

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives byte streams into uart_boot_loader and checks
// instruction-memory writes against a queue of expected writes, plus status
// outputs after each scenario. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_uart_boot_loader;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TIMEOUT = 40;
    localparam logic [7:0]  SYNC    = 8'hB0;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[16];
    int          n_tests;
    int          n_fail;

    uart_boot_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .SYNC   (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    // Scoreboard: every observed write must match the oldest expected one.
    task automatic sample();
        wr_t e;
        if (imem_we !== 1'b0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got we=%b addr %0d data %h, required no write",
                         imem_we, imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== {e.addr, e.data}) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
    endtask

    // Sends a whole frame built from words[0..n-1]; checksum is the XOR model
    // of the data bytes, optionally corrupted by csum_flip.
    task automatic send_frame(input logic [15:0] n, input logic [7:0] csum_flip,
                              input logic exp_wr);
        logic [7:0] csum;
        logic [7:0] b;
        wr_t        e;
        csum = 8'h00;
        step(1'b1, SYNC);
        step(1'b1, n[7:0]);
        step(1'b1, n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                b    = words[i][8*k +: 8];
                csum = csum ^ b;
                if (k == 3 && exp_wr) begin
                    e.addr = i[ADDR_W-1:0];
                    e.data = words[i];
                    exp_q.push_back(e);
                end
                step(1'b1, b);
            end
        end
        step(1'b1, csum ^ csum_flip);
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !==
            {1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got we=%b addr=%0d data=%h hold=%b done=%b err=%b, required 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        // Data bytes XOR to 0x90, which the frame model computes itself.
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        send_frame(16'd2, 8'h00, 1'b1);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            n_fail++;
            $display("FAIL good_frame_status: got done/hold/err=%b, required 100",
                     {done, cpu_hold, error});
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_frame_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_done_ignores();
        step(1'b1, SYNC);
        for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom));
        step(1'b1, SYNC);
        step(1'b1, 8'h02);
        n_tests++;
        if ({done, cpu_hold, error, imem_addr, imem_wdata} !==
            {3'b100, ADDR_W'(1), 32'h0010_0093}) begin
            n_fail++;
            $display("FAIL done_ignores: got status=%b addr=%0d data=%h, required 100 1 00100093",
                     {done, cpu_hold, error}, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        send_frame(16'd2, 8'h13, 1'b1);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            n_fail++;
            $display("FAIL bad_checksum_status: got done/hold/err=%b, required 011",
                     {done, cpu_hold, error});
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_checksum_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_noise_len0();
        apply_reset();
        step(1'b1, 8'h55);
        step(1'b1, 8'hAA);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b010) begin
            n_fail++;
            $display("FAIL noise_status: got done/hold/err=%b, required 010", {done, cpu_hold, error});
        end
        step(1'b1, SYNC);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            n_fail++;
            $display("FAIL len0_status: got done/hold/err=%b, required 011", {done, cpu_hold, error});
        end
        step(1'b1, 8'h42);
        step(1'b1, SYNC);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b010) begin
            n_fail++;
            $display("FAIL retry_clears_error: got done/hold/err=%b, required 010",
                     {done, cpu_hold, error});
        end
        // Back in LEN_LO: finish an N=1 frame by hand.
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        exp_q.push_back('{addr: '0, data: 32'hDEAD_BEEF});
        step(1'b1, 8'hEF);
        step(1'b1, 8'hBE);
        step(1'b1, 8'hAD);
        step(1'b1, 8'hDE);
        step(1'b1, 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
        n_tests++;
        if ({done, cpu_hold, error, exp_q.size() == 0} !== 4'b1001) begin
            n_fail++;
            $display("FAIL retry_done: got done/hold/err=%b pending=%0d, required 100 pending 0",
                     {done, cpu_hold, error}, exp_q.size());
        end
    endtask

    task automatic test_len_bound();
        apply_reset();
        step(1'b1, SYNC);
        step(1'b1, 8'd17);
        step(1'b1, 8'd0);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            n_fail++;
            $display("FAIL len_too_big: got done/hold/err=%b, required 011", {done, cpu_hold, error});
        end
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        send_frame(16'd16, 8'h00, 1'b1);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            n_fail++;
            $display("FAIL len_max_status: got done/hold/err=%b, required 100", {done, cpu_hold, error});
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len_max_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        step(1'b1, SYNC);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h13);
        idle(TIMEOUT - 1);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got error=%b, required 0", error);
        end
        idle(1);
        n_tests++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            n_fail++;
            $display("FAIL timeout_expired: got done/hold/err=%b, required 011", {done, cpu_hold, error});
        end
    endtask

    task automatic test_timeout_edge();
        apply_reset();
        step(1'b1, SYNC);
        step(1'b1, 8'h01);
        step(1'b1, 8'h00);
        step(1'b1, 8'h13);
        idle(TIMEOUT - 1);
        step(1'b1, 8'h00);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge_byte: got error=%b, required 0", error);
        end
        step(1'b1, 8'h00);
        exp_q.push_back('{addr: '0, data: 32'h0000_0013});
        step(1'b1, 8'h00);
        step(1'b1, 8'h13);
        n_tests++;
        if ({done, cpu_hold, error, exp_q.size() == 0} !== 4'b1001) begin
            n_fail++;
            $display("FAIL timeout_edge_done: got done/hold/err=%b pending=%0d, required 100 pending 0",
                     {done, cpu_hold, error}, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        step(1'b1, SYNC);
        step(1'b1, 8'h02);
        step(1'b1, 8'h00);
        step(1'b1, 8'h13);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        exp_q.push_back('{addr: '0, data: 32'h0000_0013});
        step(1'b1, 8'h00);
        step(1'b1, 8'h93);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, done, error} !==
            {1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_frame_reset: got we=%b addr=%0d data=%h hold=%b done=%b err=%b, required 0 0 0 1 0 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h00);
        step(1'b1, 8'h10);
        step(1'b1, 8'h00);
        step(1'b1, 8'h90);
        n_tests++;
        if ({done, cpu_hold, error, exp_q.size() == 0} !== 4'b0101) begin
            n_fail++;
            $display("FAIL after_reset_idle: got done/hold/err=%b pending=%0d, required 010 pending 0",
                     {done, cpu_hold, error}, exp_q.size());
        end
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        send_frame(16'd2, 8'h00, 1'b1);
        n_tests++;
        if ({done, cpu_hold, error, exp_q.size() == 0} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reload_after_reset: got done/hold/err=%b pending=%0d, required 100 pending 0",
                     {done, cpu_hold, error}, exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_good_frame();
        test_done_ignores();
        test_bad_checksum();
        test_noise_len0();
        test_len_bound();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
